// File: rtl/graph_isa_pkg.sv
// graph_isa_pkg: shared constants and types for the graph controller
// front end (instruction width, fetch FSM states).
package graph_isa_pkg;

  localparam int GRAPH_INSTR_W = 128;

  typedef enum logic [1:0] {
    GF_IDLE,
    GF_FETCH,
    GF_DRAIN
  } graph_fetch_state_e;

endpackage

// File: rtl/graph_fetch_fifo.sv
// graph_fetch_fifo: synchronous prefetch FIFO with flush and occupancy
// count; the head word reads as zero while the FIFO is empty.
module graph_fetch_fifo
  import graph_isa_pkg::*;
#(
  parameter int W     = GRAPH_INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/graph_fetch.sv
// graph_fetch: sequential program-SRAM reader feeding graph decode.
// Optional GRAPH_FETCH_PERF_EN adds the stall_cycles counter port.
module graph_fetch
  import graph_isa_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        instr_count,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [GRAPH_INSTR_W-1:0] mem_rd_data,
  output logic [GRAPH_INSTR_W-1:0] raw_instr,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     busy,
  output logic                     done
`ifdef GRAPH_FETCH_PERF_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  graph_fetch_state_e state_q;
  graph_fetch_state_e state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] outstanding_q;
  logic              rd_pend_q;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW:0]       used;
  logic              credit;
  logic              accept;
  logic              go;
  logic              last_acc;

  // Words already buffered plus the one possibly still in flight.
  assign used     = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend_q};
  assign credit   = (used < DEPTH_L);
  assign accept   = valid_out && ready_in;
  assign go       = (state_q == GF_IDLE) && start && !abort;
  assign last_acc = accept && (outstanding_q == ADDR_W'(1));

  assign valid_out   = !fifo_empty;
  assign busy        = (state_q != GF_IDLE);
  assign mem_rd_addr = addr_q;

  graph_fetch_fifo #(
    .W     (GRAPH_INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .wr_en   (rd_pend_q),
    .wr_data (mem_rd_data),
    .rd_en   (accept),
    .rd_data (raw_instr),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= GF_IDLE;
    else     state_q <= state_d;
  end

  // Next state and read strobe; abort overrides everything.
  always_comb begin
    state_d   = state_q;
    mem_rd_en = 1'b0;
    unique case (state_q)
      GF_IDLE: begin
        if (go && instr_count != '0) state_d = GF_FETCH;
      end
      GF_FETCH: begin
        if (remaining_q == '0) state_d = GF_DRAIN;
        else if (credit)       mem_rd_en = 1'b1;
      end
      GF_DRAIN: begin
        if (last_acc) state_d = GF_IDLE;
      end
      default: state_d = GF_IDLE;
    endcase
    if (abort) begin
      state_d   = GF_IDLE;
      mem_rd_en = 1'b0;
    end
  end

  // Address/count bookkeeping, in-flight flag and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      rd_pend_q     <= 1'b0;
      done          <= 1'b0;
    end else begin
      rd_pend_q <= mem_rd_en;
      done      <= !abort &&
                   ((go && instr_count == '0) || last_acc);
      if (abort) begin
        remaining_q   <= '0;
        outstanding_q <= '0;
      end else if (go) begin
        addr_q        <= base_addr;
        remaining_q   <= instr_count;
        outstanding_q <= instr_count;
      end else begin
        if (mem_rd_en) begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
        if (accept) outstanding_q <= outstanding_q - 1'b1;
      end
    end
  end

`ifdef GRAPH_FETCH_PERF_EN
  logic stall;

  assign stall = (valid_out && !ready_in) ||
                 (state_q == GF_FETCH &&
                  remaining_q != '0 && !credit);

  // Saturating stall counter, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (go)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_graph_fetch.sv
// tb_graph_fetch: vector table plus scoreboard bench for graph_fetch.
// Memory model returns a per-address pattern one cycle after each read.
module tb_graph_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [15:0]  base_addr;
  logic [15:0]  instr_count;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [127:0] mem_rd_data;
  logic [127:0] raw_instr;
  logic         valid_out;
  logic         ready_in;
  logic         busy;
  logic         done;
`ifdef GRAPH_FETCH_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  graph_fetch #(
    .ADDR_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .instr_count (instr_count),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .raw_instr   (raw_instr),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .busy        (busy),
`ifdef GRAPH_FETCH_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    int          mode;
    int          restart_k;
    int          exp_reads;
    int          exp_lat_rd;
    int          exp_lat_vld;
  } tvec_t;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [15:0]  addr_q[$];
  logic [127:0] data_q[$];

  int rd_cnt, acc_cnt, done_cnt, stall_n;
  int first_rd, first_vld, last_rd, last_acc, done_cyc;
  int start_cyc;
  bit busy_seen, prev_stall;
  logic [127:0] prev_data;

  function automatic logic [127:0] word(input logic [15:0] a);
    return {a, 16'hBEEF, ~a, 16'h1234,
            a ^ 16'h5A5A, 16'hC0DE, a + 16'd7, 16'h0F0F};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic clear_stats();
    rd_cnt = 0; acc_cnt = 0; done_cnt = 0; stall_n = 0;
    first_rd = -1; first_vld = -1; last_rd = -1;
    last_acc = -1; done_cyc = -1;
    busy_seen = 0; prev_stall = 0;
    addr_q.delete();
    data_q.delete();
  endtask

  // SRAM model: data for the strobed address one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rd_data <= word(mem_rd_addr);
    else           mem_rd_data <= {4{32'hDEAD_DEAD}};
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1;
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (addr_q.size() == 0) fail("rd_unexpected");
        else chk("rd_addr", 128'(mem_rd_addr),
                 128'(addr_q.pop_front()));
      end
      if (prev_stall && valid_out)
        chk("hold", raw_instr, prev_data);
      if (valid_out) begin
        if (first_vld < 0) first_vld = cyc;
        if (!ready_in) stall_n++;
        else begin
          acc_cnt++;
          last_acc = cyc;
          if (data_q.size() == 0) fail("acc_unexpected");
          else chk("raw_instr", raw_instr, data_q.pop_front());
        end
      end
      prev_stall = valid_out && !ready_in;
      prev_data  = raw_instr;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      1:       return (k % 2 == 0);
      2:       return (k >= 20);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run(input tvec_t v);
    bit fin;
    clear_stats();
    for (int i = 0; i < int'(v.cnt); i++) begin
      addr_q.push_back(v.base + 16'(i));
      data_q.push_back(word(v.base + 16'(i)));
    end
    @(posedge clk); #1;
    start = 1; base_addr = v.base; instr_count = v.cnt;
    ready_in = rdy(v.mode, 0);
    start_cyc = cyc;
    fin = 0;
    for (int k = 1; k < 300 && !fin; k++) begin
      @(posedge clk); #1;
      start = (k == v.restart_k);
      if (start) begin
        base_addr = 16'h0900; instr_count = 16'd5;
      end
      ready_in = rdy(v.mode, k);
      if (v.mode == 2 && k == 20) begin
        chki("stall_reads", rd_cnt, 4);
        chki("stall_valid", int'(valid_out), 1);
      end
      if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
    end
    start = 0; ready_in = 1;
    if (!fin) fail("timeout");
    chki("reads", rd_cnt, v.exp_reads);
    chki("done_cnt", done_cnt, 1);
    chki("left_words", data_q.size(), 0);
    chki("busy_end", int'(busy), 0);
    chki("busy_seen", int'(busy_seen), int'(v.cnt != 0));
    if (v.exp_lat_rd >= 0)
      chki("lat_rd", first_rd - start_cyc, v.exp_lat_rd);
    if (v.exp_lat_vld >= 0)
      chki("lat_vld", first_vld - start_cyc, v.exp_lat_vld);
    if (v.cnt == 0)
      chki("done_at", done_cyc - start_cyc, 1);
    else
      chki("done_at", done_cyc - last_acc, 1);
    if (v.mode == 0 && v.cnt != 0) begin
      chki("rd_burst", last_rd - first_rd, int'(v.cnt) - 1);
      chki("tput", last_acc - first_vld, int'(v.cnt) - 1);
    end
`ifdef GRAPH_FETCH_PERF_EN
    if (v.mode == 1 && v.cnt == 3)
      chki("stall_cycles", int'(stall_cycles), stall_n);
`endif
  endtask

  tvec_t tbl[6];
  tvec_t t2;

  initial begin
    tbl[0] = '{16'h0010, 16'd5, 0, 0, 5, 1, 3};
    tbl[1] = '{16'hFFFE, 16'd4, 0, 0, 4, 1, 3};
    tbl[2] = '{16'h0050, 16'd0, 0, 0, 0, -1, -1};
    tbl[3] = '{16'h1234, 16'd8, 2, 0, 8, 1, 3};
    tbl[4] = '{16'h0200, 16'd3, 1, 2, 3, 1, 3};
    tbl[5] = '{16'h0300, 16'd7, 1, 0, 7, 1, 3};

    rst = 1; start = 0; abort = 0; ready_in = 1;
    base_addr = '0; instr_count = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chki("rst_rd_en", int'(mem_rd_en), 0);
    chk("rst_rd_addr", 128'(mem_rd_addr), 128'd0);
    chki("rst_valid", int'(valid_out), 0);
    chk("rst_raw", raw_instr, 128'd0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_done", int'(done), 0);
    rst = 0;

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Abort the cycle after the first read is issued.
    clear_stats();
    addr_q.push_back(16'h0400);
    addr_q.push_back(16'h0401);
    @(posedge clk); #1;
    start = 1; base_addr = 16'h0400; instr_count = 16'd6;
    ready_in = 1;
    @(posedge clk); #1; start = 0;
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    addr_q.delete();
    chki("abort_valid", int'(valid_out), 0);
    chki("abort_busy", int'(busy), 0);
    repeat (6) @(posedge clk);
    #1;
    chki("abort_done", done_cnt, 0);
    chki("abort_acc", acc_cnt, 0);
    t2 = '{16'h0100, 16'd2, 0, 0, 2, 1, 3};
    run(t2);

    // Abort and start together: abort wins.
    clear_stats();
    @(posedge clk); #1;
    start = 1; abort = 1;
    base_addr = 16'h0700; instr_count = 16'd3;
    @(posedge clk); #1; start = 0; abort = 0;
    repeat (5) @(posedge clk);
    #1;
    chki("as_busy", int'(busy_seen), 0);
    chki("as_reads", rd_cnt, 0);
    chki("as_done", done_cnt, 0);

    // Reset in the middle of a stalled fetch.
    clear_stats();
    for (int i = 0; i < 6; i++)
      addr_q.push_back(16'h0800 + 16'(i));
    @(posedge clk); #1;
    start = 1; base_addr = 16'h0800; instr_count = 16'd6;
    ready_in = 0;
    @(posedge clk); #1; start = 0;
    repeat (4) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1;
    rst = 0; ready_in = 1;
    addr_q.delete();
    chki("mrst_valid", int'(valid_out), 0);
    chki("mrst_busy", int'(busy), 0);
    chk("mrst_addr", 128'(mem_rd_addr), 128'd0);
    repeat (5) @(posedge clk);
    #1;
    chki("mrst_done", done_cnt, 0);
    chki("mrst_acc", acc_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
